// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge shared definitions
// dm_ctrl encodings and access helpers
package dmem_bridge_pkg;

  typedef enum logic [2:0] {
    DM_WORD  = 3'b000,
    DM_HALF  = 3'b001,
    DM_HALFU = 3'b010,
    DM_BYTE  = 3'b011,
    DM_BYTEU = 3'b100
  } dm_ctrl_e;

  localparam int CNT_W = 8;

  // unknown codes fall back to word
  function automatic dm_ctrl_e dm_norm(input logic [2:0] c);
    dm_ctrl_e r;
    case (c)
      3'b001:  r = DM_HALF;
      3'b010:  r = DM_HALFU;
      3'b011:  r = DM_BYTE;
      3'b100:  r = DM_BYTEU;
      default: r = DM_WORD;
    endcase
    return r;
  endfunction

  function automatic logic dm_misaligned(
    input dm_ctrl_e   c,
    input logic [1:0] a
  );
    logic r;
    case (c)
      DM_WORD:           r = |a;
      DM_HALF, DM_HALFU: r = a[0];
      default:           r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge memory-bus interface
// request/response channel with modports
interface dmem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr,
    output bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr,
    input  bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/dmem_bridge_dm_align.sv
// dm_align: byte-lane steering
// store replication and load extension
module dm_align
  import dmem_bridge_pkg::*;
(
  input  dm_ctrl_e    ctrl,
  input  logic [1:0]  off,
  input  logic        we,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] sh;

  // store lanes; loads always fetch the full word
  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    if (we) begin
      unique case (1'b1)
        (ctrl == DM_BYTE) || (ctrl == DM_BYTEU): begin
          be_o    = 4'b0001 << off;
          wdata_o = {4{wdata_i[7:0]}};
        end
        (ctrl == DM_HALF) || (ctrl == DM_HALFU): begin
          be_o    = off[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // shift the addressed lane down and extend
  always_comb begin
    sh = rdata_i >> {off, 3'b000};
    case (ctrl)
      DM_BYTE:  rdata_o = {{24{sh[7]}}, sh[7:0]};
      DM_BYTEU: rdata_o = {24'd0, sh[7:0]};
      DM_HALF:  rdata_o = {{16{sh[15]}}, sh[15:0]};
      DM_HALFU: rdata_o = {16'd0, sh[15:0]};
      default:  rdata_o = sh;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: CPU MEM stage to memory bus
// one access at a time, stalls the pipe
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [2:0]  cpu_dm_ctrl,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        misalign,
  output logic        bus_err,
  dmem_bridge_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE, S_REQ, S_RESP, S_DONE
  } state_e;

  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      rdata_q, rdata_d;
  dm_ctrl_e         ctrl_q, ctrl_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;

  logic [3:0]  be;
  logic [31:0] lane_wdata;
  logic [31:0] ld_data;
  logic        go, req, tmo;
  dm_ctrl_e    in_ctrl;

  dm_align u_align (
    .ctrl    (ctrl_q),
    .off     (addr_q[1:0]),
    .we      (we_q),
    .wdata_i (wdata_q),
    .rdata_i (bus.bus_rdata),
    .be_o    (be),
    .wdata_o (lane_wdata),
    .rdata_o (ld_data)
  );

  assign go      = cpu_re | cpu_we;
  assign req     = (state_q == S_REQ);
  assign tmo     = (cnt_q >= TO_LAST);
  assign in_ctrl = dm_norm(cpu_dm_ctrl);

  // next state; gnt/rvalid win over timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ctrl_d  = ctrl_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (go) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          ctrl_d  = in_ctrl;
          we_d    = cpu_we;
          cnt_d   = '0;
          rdata_d = '0;
          if (dm_misaligned(in_ctrl, cpu_addr[1:0])) begin
            state_d = S_DONE;
            mis_d   = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (bus.bus_gnt) begin
          state_d = we_q ? S_DONE : S_RESP;
          cnt_d   = cnt_q + 1'b1;
        end else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.bus_rvalid) begin
          rdata_d = ld_data;
          state_d = S_DONE;
        end else if (tmo) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and capture registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ctrl_q  <= DM_WORD;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ctrl_q  <= ctrl_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign bus.bus_req   = req;
  assign bus.bus_we    = req & we_q;
  assign bus.bus_addr  = req ? {addr_q[31:2], 2'b00} : '0;
  assign bus.bus_be    = req ? be : '0;
  assign bus.bus_wdata = req ? lane_wdata : '0;

  assign cpu_rdata = (state_q == S_DONE) ? rdata_q : '0;
  assign cpu_stall = reset &
                     (((state_q == S_IDLE) & go) |
                      (state_q == S_REQ) |
                      (state_q == S_RESP));
  assign misalign  = mis_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed vectors
// default-timeout DUT plus a TIMEOUT_CYC=4 DUT
module tb_dmem_bridge;

  logic clk;
  logic reset;

  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_we, cpu_re, cpu_stall;
  logic [2:0]  cpu_dm_ctrl;
  logic        misalign, bus_err;

  logic [31:0] t_addr, t_wdata, t_rdata;
  logic        t_we, t_re, t_stall;
  logic [2:0]  t_ctrl;
  logic        t_mis, t_err;

  int vectors;
  int miscompares;

  dmem_bridge_if bif ();
  dmem_bridge_if tbif ();

  dmem_bridge u_dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_we      (cpu_we),
    .cpu_re      (cpu_re),
    .cpu_dm_ctrl (cpu_dm_ctrl),
    .cpu_rdata   (cpu_rdata),
    .cpu_stall   (cpu_stall),
    .misalign    (misalign),
    .bus_err     (bus_err),
    .bus         (bif.master)
  );

  dmem_bridge #(.TIMEOUT_CYC(4)) u_to (
    .clk         (clk),
    .reset       (reset),
    .cpu_addr    (t_addr),
    .cpu_wdata   (t_wdata),
    .cpu_we      (t_we),
    .cpu_re      (t_re),
    .cpu_dm_ctrl (t_ctrl),
    .cpu_rdata   (t_rdata),
    .cpu_stall   (t_stall),
    .misalign    (t_mis),
    .bus_err     (t_err),
    .bus         (tbif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cpu_we      = 1'b0;
    cpu_re      = 1'b0;
    cpu_dm_ctrl = 3'b000;
    t_addr      = '0;
    t_wdata     = '0;
    t_we        = 1'b0;
    t_re        = 1'b0;
    t_ctrl      = 3'b000;
    bif.bus_gnt    = 1'b0;
    bif.bus_rvalid = 1'b0;
    bif.bus_rdata  = '0;
    tbif.bus_gnt    = 1'b0;
    tbif.bus_rvalid = 1'b0;
    tbif.bus_rdata  = '0;

    // reset state
    #2;
    check("rst_req", bif.bus_req, 0);
    check("rst_we", bif.bus_we, 0);
    check("rst_be", bif.bus_be, 0);
    check("rst_addr", bif.bus_addr, 0);
    check("rst_wdata", bif.bus_wdata, 0);
    check("rst_rdata", cpu_rdata, 0);
    check("rst_mis", misalign, 0);
    check("rst_err", bus_err, 0);
    check("rst_stall", cpu_stall, 0);
    check("rst_to_req", tbif.bus_req, 0);
    tick();
    tick();
    reset = 1'b1;

    // load byte 0x103
    tick();
    cpu_re = 1'b1;
    cpu_addr = 32'h103;
    cpu_dm_ctrl = 3'b011;
    #1;
    check("ldb_c0_stall", cpu_stall, 1);
    check("ldb_c0_req", bif.bus_req, 0);
    tick();
    check("ldb_req", bif.bus_req, 1);
    check("ldb_addr", bif.bus_addr, 32'h100);
    check("ldb_be", bif.bus_be, 4'hF);
    check("ldb_we", bif.bus_we, 0);
    check("ldb_c1_stall", cpu_stall, 1);
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata = 32'h80FF_1234;
    #1;
    check("ldb_c2_stall", cpu_stall, 1);
    check("ldb_c2_req", bif.bus_req, 0);
    tick();
    bif.bus_rvalid = 1'b0;
    cpu_re = 1'b0;
    #1;
    check("ldb_done_stall", cpu_stall, 0);
    check("ldb_rdata", cpu_rdata, 32'hFFFF_FF80);
    check("ldb_err", bus_err, 0);
    tick();
    check("ldb_idle_rdata", cpu_rdata, 0);

    // store half 0x22
    cpu_we = 1'b1;
    cpu_addr = 32'h22;
    cpu_wdata = 32'h0000_ABCD;
    cpu_dm_ctrl = 3'b001;
    #1;
    check("sth_c0_stall", cpu_stall, 1);
    tick();
    check("sth_we", bif.bus_we, 1);
    check("sth_be", bif.bus_be, 4'b1100);
    check("sth_wdata", bif.bus_wdata, 32'hABCD_ABCD);
    check("sth_addr", bif.bus_addr, 32'h20);
    check("sth_c1_stall", cpu_stall, 1);
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    cpu_we = 1'b0;
    #1;
    check("sth_done_stall", cpu_stall, 0);
    check("sth_done_req", bif.bus_req, 0);
    tick();

    // misaligned word load 0x41
    cpu_re = 1'b1;
    cpu_addr = 32'h41;
    cpu_dm_ctrl = 3'b000;
    #1;
    check("mis_c0_stall", cpu_stall, 1);
    tick();
    cpu_re = 1'b0;
    #1;
    check("mis_pulse", misalign, 1);
    check("mis_req", bif.bus_req, 0);
    check("mis_rdata", cpu_rdata, 0);
    check("mis_stall", cpu_stall, 0);
    tick();
    check("mis_clear", misalign, 0);

    // unlisted ctrl store acts as word
    cpu_we = 1'b1;
    cpu_addr = 32'h44;
    cpu_wdata = 32'h1234_5678;
    cpu_dm_ctrl = 3'b111;
    #1;
    tick();
    check("stx_be", bif.bus_be, 4'hF);
    check("stx_wdata", bif.bus_wdata, 32'h1234_5678);
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    cpu_we = 1'b0;
    #1;
    check("stx_done_stall", cpu_stall, 0);
    tick();

    // slow byte-unsigned load, stray rvalid in REQ
    cpu_re = 1'b1;
    cpu_addr = 32'h102;
    cpu_dm_ctrl = 3'b100;
    #1;
    tick();
    check("lbu_req1", bif.bus_req, 1);
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata = 32'hDEAD_BEEF;
    tick();
    check("lbu_req2", bif.bus_req, 1);
    check("lbu_addr2", bif.bus_addr, 32'h100);
    bif.bus_rvalid = 1'b0;
    tick();
    check("lbu_req3", bif.bus_req, 1);
    tick();
    check("lbu_req4", bif.bus_req, 1);
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    #1;
    check("lbu_resp1_req", bif.bus_req, 0);
    check("lbu_resp1_stall", cpu_stall, 1);
    tick();
    check("lbu_resp2_stall", cpu_stall, 1);
    tick();
    check("lbu_resp3_stall", cpu_stall, 1);
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata = 32'h00AB_0000;
    tick();
    bif.bus_rvalid = 1'b0;
    cpu_re = 1'b0;
    #1;
    check("lbu_rdata", cpu_rdata, 32'h0000_00AB);
    check("lbu_stall", cpu_stall, 0);
    check("lbu_err", bus_err, 0);
    tick();

    // timeout with gnt withheld (TIMEOUT_CYC=4)
    t_re = 1'b1;
    t_addr = 32'h10;
    t_ctrl = 3'b000;
    #1;
    check("to_c0_stall", t_stall, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("to_req", tbif.bus_req, 1);
    end
    tick();
    t_re = 1'b0;
    #1;
    check("to_err", t_err, 1);
    check("to_req_drop", tbif.bus_req, 0);
    check("to_rdata", t_rdata, 0);
    check("to_stall", t_stall, 0);
    tick();
    check("to_err_clear", t_err, 0);
    check("to_idle_stall", t_stall, 0);

    // gnt on last cycle beats timeout
    t_re = 1'b1;
    t_addr = 32'h0;
    t_ctrl = 3'b011;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pri_req", tbif.bus_req, 1);
    end
    tick();
    check("pri_req4", tbif.bus_req, 1);
    tbif.bus_gnt = 1'b1;
    tick();
    tbif.bus_gnt = 1'b0;
    tbif.bus_rvalid = 1'b1;
    tbif.bus_rdata = 32'h0000_007F;
    #1;
    check("pri_resp_stall", t_stall, 1);
    check("pri_resp_err", t_err, 0);
    tick();
    tbif.bus_rvalid = 1'b0;
    t_re = 1'b0;
    #1;
    check("pri_err", t_err, 0);
    check("pri_rdata", t_rdata, 32'h0000_007F);
    tick();

    // reset while in RESP
    cpu_re = 1'b1;
    cpu_addr = 32'h200;
    cpu_dm_ctrl = 3'b000;
    #1;
    tick();
    bif.bus_gnt = 1'b1;
    tick();
    bif.bus_gnt = 1'b0;
    #1;
    check("rr_resp_stall", cpu_stall, 1);
    reset = 1'b0;
    #1;
    check("rr_stall", cpu_stall, 0);
    check("rr_req", bif.bus_req, 0);
    check("rr_addr", bif.bus_addr, 0);
    check("rr_rdata", cpu_rdata, 0);
    bif.bus_rvalid = 1'b1;
    bif.bus_rdata = 32'hCAFE_F00D;
    cpu_re = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    bif.bus_rvalid = 1'b0;
    #1;
    check("rr_post_stall", cpu_stall, 0);
    check("rr_post_req", bif.bus_req, 0);
    check("rr_post_mis", misalign, 0);
    check("rr_post_err", bus_err, 0);
    check("rr_post_rdata", cpu_rdata, 0);
    tick();
    check("rr_idle_rdata", cpu_rdata, 0);
    check("rr_idle_err", bus_err, 0);
    check("rr_idle_stall", cpu_stall, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, SHALL set the maximum number of cycles spent in REQ+RESP before an access is aborted (legal range 1..255).
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  in  1  SHALL be the asynchronous, active-low reset.
REQ-004 cpu_addr  in  32  SHALL be the byte address from the CPU MEM stage (ALU result).
REQ-005 cpu_wdata  in  32  SHALL be the store data from the CPU MEM stage (rs2 value).
REQ-006 cpu_we  in  1  SHALL request a store; cpu_re  in  1  SHALL request a load; both high SHALL be treated as a store.
REQ-007 cpu_dm_ctrl  in  3  SHALL select the access width/extension: word, halfword, halfword-unsigned, byte, byte-unsigned.
REQ-008 cpu_rdata  out  32  SHALL carry the aligned, extended load result.
REQ-009 cpu_stall  out  1  SHALL freeze the CPU pipeline while high.
REQ-010 misalign  out  1  and bus_err  out  1  SHALL each be single-cycle error pulses.
REQ-011 bus_req  out  1, bus_we  out  1, bus_addr  out  32 (bits [1:0] always 0), bus_be  out  4, bus_wdata  out  32 SHALL form the memory-bus request.
REQ-012 bus_gnt  in  1, bus_rvalid  in  1, bus_rdata  in  32 SHALL form the memory-bus response.

Function
REQ-013 FSM states SHALL be IDLE, REQ, RESP and DONE.
REQ-014 IDLE: on (cpu_re|cpu_we), the block SHALL latch address, data, ctrl and direction, then go to REQ; if the access is misaligned it SHALL go directly to DONE.
REQ-015 Misalignment SHALL be: word with addr[1:0]!=0, or halfword with addr[0]=1; it SHALL produce no bus transaction, a misalign pulse in DONE and cpu_rdata=0.
REQ-016 REQ: bus_req SHALL be high and request fields stable until bus_gnt; on gnt a load SHALL go to RESP and a store SHALL go to DONE.
REQ-017 RESP: on bus_rvalid, bus_rdata SHALL be captured and the state SHALL go to DONE; rvalid outside RESP SHALL be ignored.
REQ-018 DONE SHALL last exactly one cycle, with cpu_stall=0 and cpu_rdata valid from the capture register; it SHALL then return to IDLE.
REQ-019 cpu_stall SHALL equal (cpu_re|cpu_we) in IDLE, 1 in REQ and RESP, and 0 in DONE and in an idle IDLE.
REQ-020 Minimum latency SHALL be 3 stall cycles for a load (gnt in the first REQ cycle, rvalid in the first RESP cycle) and 2 stall cycles for a store.
REQ-021 Store lanes:
- byte: bus_be=1<<addr[1:0], byte replicated ×4;
- half: bus_be=addr[1]?4'b1100:4'b0011, half replicated ×2;
- word: bus_be=4'b1111.
REQ-022 Loads SHALL set bus_be=4'b1111, then shift by addr[1:0]×8 and sign- or zero-extend according to ctrl.
REQ-023 A timeout counter SHALL clear on entering REQ and increment each REQ/RESP cycle; on reaching TIMEOUT_CYC it SHALL drop bus_req, go to DONE with a bus_err pulse and cpu_rdata=0.
REQ-024 gnt or rvalid arriving in the same cycle as the timeout SHALL take priority over the timeout.
REQ-025 Unlisted cpu_dm_ctrl codes SHALL be treated as word.

Reset
REQ-026 reset low SHALL asynchronously force IDLE and clear the counter and capture registers.
REQ-027 During reset: bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, cpu_rdata=0, misalign=0, bus_err=0, cpu_stall=0.
REQ-028 Reset asserted mid-transaction SHALL abandon the access with no completion pulse after release.

Structure
REQ-029 The dm_ctrl encodings (word 000, half 001, half-unsigned 010, byte 011, byte-unsigned 100) SHALL come from the shared ctrl_encode_def definitions; FSM state codes SHALL stay local.
REQ-030 Byte-lane steering and load extension SHALL live in one combinational sub-module, dm_align.

Verification
REQ-031 Load byte: addr 0x103, bus_rdata 0x80FF_1234 → bus_addr 0x100, cpu_rdata 0xFFFF_FF80, 3 stall cycles.
REQ-032 Store half: addr 0x22, wdata 0x0000_ABCD → bus_be 1100, bus_wdata 0xABCD_ABCD, 2 stall cycles.
REQ-033 Load word at 0x41 → no bus_req, misalign pulse, cpu_rdata 0, 1 stall cycle.
REQ-034 Load with bus_gnt withheld, TIMEOUT_CYC=4 → bus_err pulse after 4 REQ cycles, cpu_rdata 0, return to IDLE.
REQ-035 Load with gnt after 3 cycles and rvalid after 2 more cycles, byte-unsigned at offset 2 of 0x00AB_0000 → cpu_rdata 0x0000_00AB.
REQ-036 reset pulsed low while in RESP → bus_req=0 immediately, IDLE after release, no stale cpu_rdata or pulse.
